// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator and pixel-fetch controller
// Optional colour-bar source selected by defining VGA_TESTPAT_EN (adds the test_en input).
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 29,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CW       = 4,
   parameter int RD_LAT   = 1
) (
   input  logic            clk,
   input  logic            clr_n,
`ifdef VGA_TESTPAT_EN
   input  logic            test_en,
`endif
   input  logic [3*CW-1:0] rgb_in,
   output logic [9:0]      h_addr,
   output logic [8:0]      v_addr,
   output logic            read,
   output logic            hsync,
   output logic            vsync,
   output logic            de,
   output logic [CW-1:0]   r,
   output logic [CW-1:0]   g,
   output logic [CW-1:0]   b,
   output logic            line_start,
   output logic            frame_start,
   output logic [7:0]      frame_cnt
);

   localparam int HT    = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int VT    = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_OFS = H_SYNC + H_BP;
   localparam int V_OFS = V_SYNC + V_BP;

   // Delay-line bit positions and their inactive (reset) pattern
   localparam int DL_HS = 4;
   localparam int DL_VS = 3;
   localparam int DL_DE = 2;
   localparam int DL_LS = 1;
   localparam int DL_FS = 0;
   localparam logic [4:0] DL_IDLE = {~H_POL, ~V_POL, 3'b000};

   if (HT > 1024 || VT > 1024) begin : g_chk_total
      $error("vga_timing_gen: HT and VT must not exceed 1024");
   end
   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_zero
      $error("vga_timing_gen: every timing region must be at least one unit wide");
   end
   if (RD_LAT < 0 || RD_LAT > 7) begin : g_chk_lat
      $error("vga_timing_gen: RD_LAT must be in 0..7");
   end

   logic [9:0]      r_hc;
   logic [9:0]      r_vc;
   logic            w_h_last;
   logic            w_v_last;
   logic            w_h_act;
   logic            w_v_act;
   logic            w_act;
   logic [9:0]      w_hx;
   logic [8:0]      w_vy;
   logic [4:0]      w_raw;
   logic [4:0]      r_dl [0:RD_LAT+1];
   logic [9:0]      r_h_addr;
   logic [8:0]      r_v_addr;
   logic [3*CW-1:0] w_src;
   logic [3*CW-1:0] r_rgb;
   logic [7:0]      r_frame_cnt;

   assign w_h_last = (r_hc == 10'(HT - 1));
   assign w_v_last = (r_vc == 10'(VT - 1));
   assign w_h_act  = (r_hc >= 10'(H_OFS)) && (r_hc < 10'(H_OFS + H_ACTIVE));
   assign w_v_act  = (r_vc >= 10'(V_OFS)) && (r_vc < 10'(V_OFS + V_ACTIVE));
   assign w_act    = w_h_act && w_v_act;
   assign w_hx     = r_hc - 10'(H_OFS);
   assign w_vy     = 9'(r_vc - 10'(V_OFS));

   assign w_raw = {(r_hc < 10'(H_SYNC)) ? H_POL : ~H_POL,
                   (r_vc < 10'(V_SYNC)) ? V_POL : ~V_POL,
                   w_act,
                   w_act && (w_hx == 10'd0),
                   w_act && (w_hx == 10'd0) && (w_vy == 9'd0)};

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_hc <= 10'd0;
         r_vc <= 10'd0;
      end else if (w_h_last) begin
         r_hc <= 10'd0;
         r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
      end else begin
         r_hc <= r_hc + 10'd1;
      end
   end

   // r_dl[0] is the stage-1 register; the remaining RD_LAT+1 stages match the read path
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_h_addr <= 10'd0;
         r_v_addr <= 9'd0;
         for (int k = 0; k <= RD_LAT + 1; k++) begin
            r_dl[k] <= DL_IDLE;
         end
      end else begin
         r_dl[0] <= w_raw;
         for (int k = 1; k <= RD_LAT + 1; k++) begin
            r_dl[k] <= r_dl[k-1];
         end
         if (w_act) begin
            r_h_addr <= w_hx;
            r_v_addr <= w_vy;
         end
      end
   end

`ifdef VGA_TESTPAT_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [9:0] r_bar_px;
   logic [2:0] r_bar_k [0:RD_LAT];
   logic [2:0] w_bar_c;

   // Bar index tracks h_addr at stage 1, then rides alongside the read latency
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_bar_px <= 10'd0;
         for (int k = 0; k <= RD_LAT; k++) begin
            r_bar_k[k] <= 3'd0;
         end
      end else begin
         for (int k = 1; k <= RD_LAT; k++) begin
            r_bar_k[k] <= r_bar_k[k-1];
         end
         if (w_act) begin
            if (w_hx == 10'd0) begin
               r_bar_px   <= 10'd0;
               r_bar_k[0] <= 3'd0;
            end else if (r_bar_px == 10'(BAR_W - 1)) begin
               r_bar_px   <= 10'd0;
               r_bar_k[0] <= r_bar_k[0] + 3'd1;
            end else begin
               r_bar_px <= r_bar_px + 10'd1;
            end
         end
      end
   end

   assign w_bar_c = ~r_bar_k[RD_LAT];
   assign w_src   = test_en ? {{CW{w_bar_c[2]}}, {CW{w_bar_c[1]}}, {CW{w_bar_c[0]}}} : rgb_in;
`else
   assign w_src = rgb_in;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_rgb       <= '0;
         r_frame_cnt <= 8'd0;
      end else begin
         r_rgb <= r_dl[RD_LAT][DL_DE] ? w_src : '0;
         if (r_dl[RD_LAT][DL_FS]) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign h_addr      = r_h_addr;
   assign v_addr      = r_v_addr;
   assign read        = r_dl[0][DL_DE];
   assign hsync       = r_dl[RD_LAT+1][DL_HS];
   assign vsync       = r_dl[RD_LAT+1][DL_VS];
   assign de          = r_dl[RD_LAT+1][DL_DE];
   assign line_start  = r_dl[RD_LAT+1][DL_LS];
   assign frame_start = r_dl[RD_LAT+1][DL_FS];
   assign r           = r_rgb[3*CW-1:2*CW];
   assign g           = r_rgb[2*CW-1:CW];
   assign b           = r_rgb[CW-1:0];
   assign frame_cnt   = r_frame_cnt;

endmodule
